// File: rtl/fp_lsu.sv
// fp_lsu: FLW/FSW load/store unit between data memory and the FP register file.
// Ports: req_* handshake in; fra/fra_data FP read; fwe/fwa/fwd FP write; mem_* data port; done/misalign pulses.
module fp_lsu #(
  parameter int SCALE = 5,
  parameter int WIDTH = 32,
  parameter int AW    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_store,
  input  logic [AW-1:0]    req_base,
  input  logic [11:0]      req_imm,
  input  logic [SCALE-1:0] req_frd,
  input  logic [SCALE-1:0] req_frs,
  output logic [SCALE-1:0] fra,
  input  logic [WIDTH-1:0] fra_data,
  output logic             fwe,
  output logic [SCALE-1:0] fwa,
  output logic [WIDTH-1:0] fwd,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             done,
  output logic             misalign
);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, FIN, ERR
  } state_t;

  state_t state, nxt;

  logic [AW-1:0]    addr_q;
  logic             store_q;
  logic [SCALE-1:0] frd_q;
  logic [WIDTH-1:0] data_q;
  logic [AW-1:0]    ea;
  logic             accept;

  assign ea = req_base
            + {{(AW-12){req_imm[11]}}, req_imm};
  assign accept = (state == IDLE) && req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      store_q <= 1'b0;
      frd_q   <= '0;
      data_q  <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        addr_q  <= ea;
        store_q <= req_store;
        frd_q   <= req_frd;
        // store word is sampled from the read port in the accept cycle
        data_q  <= req_store ? fra_data : '0;
      end
      if (state == WAIT && mem_rvalid)
        data_q <= mem_rdata;
    end
  end

  always_comb begin
    nxt       = state;
    req_ready = 1'b0;
    fra       = '0;
    fwe       = 1'b0;
    fwa       = '0;
    fwd       = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done      = 1'b0;
    misalign  = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        fra       = req_frs;
        if (req_valid)
          nxt = (ea[1:0] != 2'b00) ? ERR : REQ;
      end
      REQ: begin
        mem_req   = 1'b1;
        mem_we    = store_q;
        mem_addr  = addr_q;
        mem_wdata = store_q ? data_q : '0;
        if (mem_gnt)
          nxt = store_q ? FIN : WAIT;
      end
      WAIT: begin
        if (mem_rvalid)
          nxt = FIN;
      end
      FIN: begin
        done = 1'b1;
        if (!store_q) begin
          fwe = 1'b1;
          fwa = frd_q;
          fwd = data_q;
        end
        nxt = IDLE;
      end
      ERR: begin
        misalign = 1'b1;
        nxt      = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fp_lsu.sv
// tb_fp_lsu: directed and randomized checks of fp_lsu against a
// transaction-level timing model of FLW/FSW.
module tb_fp_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_store;
  logic [31:0] req_base;
  logic [11:0] req_imm;
  logic [4:0]  req_frd, req_frs, fra, fwa;
  logic [31:0] fra_data, fwd;
  logic        fwe, mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        done, misalign;

  logic [31:0] rf [32];
  int tests = 0;
  int fails = 0;

  assign fra_data = rf[fra];

  always #5 clk = ~clk;

  fp_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_base(req_base),
    .req_imm(req_imm), .req_frd(req_frd),
    .req_frs(req_frs), .fra(fra), .fra_data(fra_data),
    .fwe(fwe), .fwa(fwa), .fwd(fwd),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .done(done), .misalign(misalign)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_base   = '0;
    req_imm    = '0;
    req_frd    = '0;
    req_frs    = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_fwe"}, fwe, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mis"}, misalign, 0);
  endtask

  // One instruction from accept to the cycle after completion.
  // gd/rd: cycles of gnt/rvalid delay. Cycle c is relative to
  // the accept cycle T0; every output is predicted for each c.
  task automatic op(input bit st,
                    input logic [31:0] base,
                    input logic [11:0] imm,
                    input logic [4:0] frd,
                    input logic [4:0] frs,
                    input int gd, input int rd,
                    input logic [31:0] rdata);
    int off;
    logic [31:0] ea, wd;
    bit mis, in_req, gnt_c, rv_c;
    int last;
    off  = imm[11] ? int'(imm) - 4096 : int'(imm);
    ea   = base + 32'(off);
    mis  = (ea % 4) != 0;
    last = mis ? 1 : (st ? 2 + gd : 3 + gd + rd);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_store = st;
    req_base  = base;
    req_imm   = imm;
    req_frd   = frd;
    req_frs   = frs;
    wd        = rf[frs];
    @(negedge clk);
    chk("t0_ready", req_ready, 1);
    chk("t0_fra", fra, frs);
    for (int c = 1; c <= last + 1; c++) begin
      in_req = !mis && c <= 1 + gd;
      gnt_c  = in_req && c == 1 + gd;
      rv_c   = !mis && !st && c == 2 + gd + rd;
      @(posedge clk); #1;
      // busy-time noise on the request side must be ignored
      req_valid = (c <= last) ? 1'($urandom) : 1'b0;
      req_store = 1'($urandom);
      req_base  = $urandom;
      req_imm   = 12'($urandom);
      req_frd   = 5'($urandom);
      req_frs   = 5'($urandom);
      mem_gnt   = in_req ? gnt_c : 1'($urandom);
      if (!mis && !st && c >= 2 + gd && c <= 2 + gd + rd)
        mem_rvalid = rv_c;
      else
        mem_rvalid = 1'($urandom);
      mem_rdata = rv_c ? rdata : $urandom;
      @(negedge clk);
      chk("ready", req_ready, (c == last + 1) ? 1 : 0);
      chk("mem_req", mem_req, in_req ? 1 : 0);
      chk("mem_we", mem_we, (in_req && st) ? 1 : 0);
      chk("mem_addr", mem_addr, in_req ? ea : 0);
      chk("mem_wdata", mem_wdata, (in_req && st) ? wd : 0);
      chk("done", done, (!mis && c == last) ? 1 : 0);
      chk("fwe", fwe, (!mis && !st && c == last) ? 1 : 0);
      chk("fwa", fwa, (!mis && !st && c == last) ? frd : 0);
      chk("fwd", fwd, (!mis && !st && c == last) ? rdata : 0);
      chk("misalign", misalign, (mis && c == 1) ? 1 : 0);
    end
    @(posedge clk); #1;
    idle_in();
  endtask

  initial begin
    logic [31:0] b;
    logic [11:0] im;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    idle_in();
    rst_n = 1'b0;
    #12;
    chk("rst_ready", req_ready, 1);
    chk_quiet("rst");
    chk("rst_fwa", fwa, 0);
    chk("rst_fwd", fwd, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;

    // FLW: 0x100+4, single-cycle gnt and rvalid
    op(1'b0, 32'h100, 12'h004, 5'd5, 5'd0, 0, 0, 32'h3F000000);
    // FSW with 3 cycles of gnt stall, negative offset
    rf[3] = 32'h3F68F5C2;
    op(1'b1, 32'h200, 12'hFFC, 5'd0, 5'd3, 3, 0, 32'h0);
    // misaligned
    op(1'b0, 32'h102, 12'h000, 5'd1, 5'd0, 0, 0, 32'h0);
    op(1'b1, 32'h101, 12'h002, 5'd1, 5'd4, 0, 0, 32'h0);
    // address wrap
    op(1'b0, 32'hFFFFFFFC, 12'h008, 5'd7, 5'd0, 1, 2, 32'hCAFEF00D);
    op(1'b1, 32'hFFFFFFFC, 12'h008, 5'd0, 5'd9, 0, 0, 32'h0);

    // async reset while in REQ
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_base  = 32'h300;
    req_frd   = 5'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rq_mem_req", mem_req, 1);
    chk("rq_addr", mem_addr, 32'h300);
    #1 rst_n = 1'b0;
    #1;
    chk("rq_ready", req_ready, 1);
    chk("rq_addr0", mem_addr, 0);
    chk_quiet("rq");
    @(posedge clk); #3;
    rst_n = 1'b1;
    op(1'b0, 32'h400, 12'h008, 5'd9, 5'd0, 1, 1, 32'h12345678);

    // reset in WAIT, then stray rvalid while idle
    @(posedge clk); #1;
    idle_in();
    req_valid = 1'b1;
    req_base  = 32'h500;
    req_frd   = 5'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_gnt   = 1'b1;
    @(negedge clk);
    chk("sw_req", mem_req, 1);
    @(posedge clk); #1;
    mem_gnt   = 1'b0;
    req_valid = 1'b1;
    req_base  = 32'h600;
    @(negedge clk);
    chk("sw_ready", req_ready, 0);
    chk("sw_req0", mem_req, 0);
    #1 rst_n = 1'b0;
    #1 chk("sw_rst_ready", req_ready, 1);
    req_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEADBEEF;
      @(negedge clk);
      chk_quiet("stray");
      chk("stray_ready", req_ready, 1);
    end
    @(posedge clk); #1;
    idle_in();

    // randomized mix
    for (int n = 0; n < 60; n++) begin
      b  = $urandom;
      im = 12'($urandom);
      if ($urandom_range(3) != 0) begin
        b[1:0]  = 2'b00;
        im[1:0] = 2'b00;
      end
      op(1'($urandom), b, im, 5'($urandom), 5'($urandom),
         $urandom_range(3), $urandom_range(3), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
